uart_tx_arbiter: RTL and testbench

//  Shares one UART transmit line between NUM_REQ byte producers using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares a single UART TX line between NUM_REQ byte
// producers. Each granted byte is sent as one start bit, 8 data bits LSB first
// and STOP_BITS stop bits. Bit timing comes from a clk_50m tick counter; no
// derived clocks are used.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REQ      = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk_50m,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic [1:0]             cur_src,
  output logic                   tx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [15:0] TICK_MAX  = 16'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  RR_RESET  = 2'(NUM_REQ - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  // Cyclic search starting at last+1. Returns {found, index}. The loop walks
  // from the farthest candidate to the nearest so the nearest one wins.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                         input logic [1:0]         last_v);
    logic [2:0] cand;
    logic [2:0] result;
    result = 3'b000;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_v} + 3'(k);
      if (cand >= 3'(NUM_REQ)) begin
        cand = cand - 3'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (req_v[cand[1:0]]) begin
        result = {1'b1, cand[1:0]};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Select the byte belonging to requester idx_v from the flattened bus.
  function automatic logic [7:0] byte_sel(input logic [8*NUM_REQ-1:0] data_v,
                                          input logic [1:0]           idx_v);
    logic [7:0] result;
    result = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx_v == 2'(i)) begin
        result = data_v[8*i +: 8];
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  state_t               state_r, state_next_s;
  logic [15:0]          tick_r, tick_next_s;
  logic [2:0]           bit_idx_r, bit_idx_next_s;
  logic                 stop_cnt_r, stop_cnt_next_s;
  logic [7:0]           shift_r, shift_next_s;
  logic [1:0]           rr_last_r, rr_last_next_s;
  logic [1:0]           cur_src_r, cur_src_next_s;
  logic [NUM_REQ-1:0]   ack_r, ack_next_s;
  logic                 busy_r, busy_next_s;
  logic                 tx_r, tx_next_s;

  logic [2:0]           pick_s;
  logic                 grant_valid_s;
  logic [1:0]           grant_idx_s;
  logic [7:0]           grant_byte_s;
  logic                 tick_end_s;

  assign pick_s        = rr_pick(req, rr_last_r);
  assign grant_valid_s = pick_s[2];
  assign grant_idx_s   = pick_s[1:0];
  assign grant_byte_s  = byte_sel(data, grant_idx_s);
  assign tick_end_s    = (tick_r == TICK_MAX);

  // State register.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: a phase ends on the last tick of its final bit.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_end_s) begin
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_end_s && (bit_idx_r == 3'd7)) begin
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_end_s && (stop_cnt_r == STOP_LAST)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values; tx is computed one cycle ahead so the
  // line changes on the same edge as the state.
  always_comb begin
    tick_next_s     = tick_r;
    bit_idx_next_s  = bit_idx_r;
    stop_cnt_next_s = stop_cnt_r;
    shift_next_s    = shift_r;
    rr_last_next_s  = rr_last_r;
    cur_src_next_s  = cur_src_r;
    ack_next_s      = '0;
    busy_next_s     = busy_r;
    tx_next_s       = tx_r;
    case (state_r)
      ST_IDLE: begin
        tick_next_s     = 16'd0;
        bit_idx_next_s  = 3'd0;
        stop_cnt_next_s = 1'b0;
        if (grant_valid_s) begin
          shift_next_s   = grant_byte_s;
          rr_last_next_s = grant_idx_s;
          cur_src_next_s = grant_idx_s;
          ack_next_s     = NUM_REQ'(1) << grant_idx_s;
          busy_next_s    = 1'b1;
          tx_next_s      = 1'b0;
        end else begin
          busy_next_s    = 1'b0;
          tx_next_s      = 1'b1;
        end
      end
      ST_START: begin
        if (tick_end_s) begin
          tick_next_s = 16'd0;
          tx_next_s   = shift_r[0];
        end else begin
          tick_next_s = tick_r + 16'd1;
        end
      end
      ST_DATA: begin
        if (tick_end_s) begin
          tick_next_s = 16'd0;
          if (bit_idx_r == 3'd7) begin
            bit_idx_next_s = 3'd0;
            tx_next_s      = 1'b1;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
            shift_next_s   = {1'b0, shift_r[7:1]};
            tx_next_s      = shift_r[1];
          end
        end else begin
          tick_next_s = tick_r + 16'd1;
        end
      end
      ST_STOP: begin
        if (tick_end_s) begin
          tick_next_s = 16'd0;
          if (stop_cnt_r == STOP_LAST) begin
            stop_cnt_next_s = 1'b0;
            busy_next_s     = 1'b0;
          end else begin
            stop_cnt_next_s = stop_cnt_r + 1'b1;
          end
        end else begin
          tick_next_s = tick_r + 16'd1;
        end
      end
      default: begin
        tick_next_s     = 16'd0;
        bit_idx_next_s  = 3'd0;
        stop_cnt_next_s = 1'b0;
        busy_next_s     = 1'b0;
        tx_next_s       = 1'b1;
      end
    endcase
  end

  // Datapath and output registers; reset forces the line idle at once.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      tick_r     <= 16'd0;
      bit_idx_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      shift_r    <= 8'h00;
      rr_last_r  <= RR_RESET;
      cur_src_r  <= 2'd0;
      ack_r      <= '0;
      busy_r     <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      tick_r     <= tick_next_s;
      bit_idx_r  <= bit_idx_next_s;
      stop_cnt_r <= stop_cnt_next_s;
      shift_r    <= shift_next_s;
      rr_last_r  <= rr_last_next_s;
      cur_src_r  <= cur_src_next_s;
      ack_r      <= ack_next_s;
      busy_r     <= busy_next_s;
      tx_r       <= tx_next_s;
    end
  end

  assign ack     = ack_r;
  assign busy    = busy_r;
  assign cur_src = cur_src_r;
  assign tx      = tx_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a default instance (434 clk/bit,
// 1 stop bit) and a small instance (4 clk/bit, 2 stop bits).
module tb_uart_tx_arbiter;

  localparam int C_A = 434;
  localparam int S_A = 1;
  localparam int C_B = 4;
  localparam int S_B = 2;

  logic        clk_50m = 1'b0;
  logic        rst;
  logic [3:0]  req_a, req_b;
  logic [31:0] data_a, data_b;
  logic [3:0]  ack_a, ack_b;
  logic        busy_a, busy_b;
  logic [1:0]  cur_src_a, cur_src_b;
  logic        tx_a, tx_b;

  logic        sel_b;
  logic [3:0]  ack_s;
  logic        busy_s;
  logic [1:0]  cur_src_s;
  logic        tx_s;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] byte_v;
  } exp_t;
  exp_t sb_q[$];

  uart_tx_arbiter #(.CLKS_PER_BIT(C_A), .NUM_REQ(4), .STOP_BITS(S_A)) dut_a (
    .clk_50m(clk_50m), .rst(rst), .req(req_a), .data(data_a),
    .ack(ack_a), .busy(busy_a), .cur_src(cur_src_a), .tx(tx_a));

  uart_tx_arbiter #(.CLKS_PER_BIT(C_B), .NUM_REQ(4), .STOP_BITS(S_B)) dut_b (
    .clk_50m(clk_50m), .rst(rst), .req(req_b), .data(data_b),
    .ack(ack_b), .busy(busy_b), .cur_src(cur_src_b), .tx(tx_b));

  assign ack_s     = sel_b ? ack_b     : ack_a;
  assign busy_s    = sel_b ? busy_b    : busy_a;
  assign cur_src_s = sel_b ? cur_src_b : cur_src_a;
  assign tx_s      = sel_b ? tx_b      : tx_a;

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
  endtask

  // Waits for an ack on the selected DUT, pops the scoreboard, then follows the
  // whole frame cycle by cycle. Returns the cycle number of the ack.
  task automatic check_frame(input int cpb, input int nstop, input logic [3:0] set_mask,
                             input logic [3:0] drop_mask, output int t_ack);
    exp_t       e;
    logic [7:0] got;
    int         wave_err;
    int         n;
    int         bi;
    logic       eb;
    bit         seen;
    seen = 1'b0;
    for (int w = 0; w < 20000; w++) begin
      if (ack_s !== 4'b0000) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_50m);
    end
    t_ack = cyc;
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL ack_timeout: got no ack, required one within 20000 cycles");
      return;
    end
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: got ack %b, required no ack (queue empty)", ack_s);
      return;
    end
    e = sb_q.pop_front();
    if (sel_b) req_b = (req_b | set_mask) & ~drop_mask;
    else       req_a = (req_a | set_mask) & ~drop_mask;
    if (ack_s !== (4'b0001 << e.src)) begin
      n_err++;
      $display("FAIL ack_vector: got %b, required %b", ack_s, 4'b0001 << e.src);
    end
    n_cmp++;
    if (cur_src_s !== e.src) begin
      n_err++;
      $display("FAIL cur_src: got %0d, required %0d", cur_src_s, e.src);
    end
    n = (9 + nstop) * cpb;
    wave_err = 0;
    got = 8'h00;
    for (int k = 0; k < n; k++) begin
      bi = k / cpb;
      if (bi == 0)      eb = 1'b0;
      else if (bi <= 8) eb = e.byte_v[bi-1];
      else              eb = 1'b1;
      if (tx_s !== eb || busy_s !== 1'b1 || (k > 0 && ack_s !== 4'b0000)) wave_err++;
      if (bi >= 1 && bi <= 8 && (k % cpb) == cpb / 2) got[bi-1] = tx_s;
      @(negedge clk_50m);
    end
    n_cmp++;
    if (wave_err != 0) begin
      n_err++;
      $display("FAIL frame_waveform: got %0d bad cycles, required 0", wave_err);
    end
    n_cmp++;
    if (got !== e.byte_v) begin
      n_err++;
      $display("FAIL frame_byte: got %h, required %h", got, e.byte_v);
    end
    n_cmp++;
    if (busy_s !== 1'b0 || tx_s !== 1'b1) begin
      n_err++;
      $display("FAIL frame_end: got busy=%b tx=%b, required busy=0 tx=1 after %0d cycles",
               busy_s, tx_s, n);
    end
  endtask

  task automatic test_reset();
    int changes;
    sel_b = 1'b0;
    req_a = 4'b0000; req_b = 4'b0000;
    data_a = 32'h0; data_b = 32'h0;
    apply_reset();
    @(negedge clk_50m);
    n_cmp++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || ack_a !== 4'b0000 || cur_src_a !== 2'd0) begin
      n_err++;
      $display("FAIL reset_a: got tx=%b busy=%b ack=%b cur_src=%0d, required 1 0 0000 0",
               tx_a, busy_a, ack_a, cur_src_a);
    end
    n_cmp++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || ack_b !== 4'b0000 || cur_src_b !== 2'd0) begin
      n_err++;
      $display("FAIL reset_b: got tx=%b busy=%b ack=%b cur_src=%0d, required 1 0 0000 0",
               tx_b, busy_b, ack_b, cur_src_b);
    end
    changes = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_50m);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || ack_a !== 4'b0000 || cur_src_a !== 2'd0) changes++;
    end
    n_cmp++;
    if (changes != 0) begin
      n_err++;
      $display("FAIL idle_quiet: got %0d changed cycles, required 0", changes);
    end
  endtask

  task automatic test_single();
    int t;
    sel_b = 1'b0;
    data_a[7:0] = 8'h55;
    req_a = 4'b0001;
    sb_q.push_back('{src: 2'd0, byte_v: 8'h55});
    check_frame(C_A, S_A, 4'b0000, 4'b0001, t);
    repeat (20) @(negedge clk_50m);
    n_cmp++;
    if (ack_a !== 4'b0000 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL single_no_repeat: got ack=%b busy=%b, required 0000 0", ack_a, busy_a);
    end
  endtask

  task automatic test_round_robin();
    int t_prev;
    int t;
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    sel_b = 1'b0;
    data_a = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 5; i++)
      sb_q.push_back('{src: order[i], byte_v: data_a[8*order[i] +: 8]});
    req_a = 4'b1111;
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      check_frame(C_A, S_A, 4'b0000, (i == 4) ? 4'b1111 : 4'b0000, t);
      if (i > 0) begin
        n_cmp++;
        if (t - t_prev != 4341) begin
          n_err++;
          $display("FAIL rr_spacing: got %0d cycles, required 4341", t - t_prev);
        end
      end
      t_prev = t;
    end
  endtask

  task automatic test_late_request();
    int t;
    sel_b = 1'b0;
    data_a[15:8]  = 8'h96;
    data_a[23:16] = 8'h0F;
    sb_q.push_back('{src: 2'd2, byte_v: 8'h0F});
    sb_q.push_back('{src: 2'd1, byte_v: 8'h96});
    sb_q.push_back('{src: 2'd2, byte_v: 8'h0F});
    req_a = 4'b0100;
    check_frame(C_A, S_A, 4'b0010, 4'b0000, t);
    check_frame(C_A, S_A, 4'b0000, 4'b0010, t);
    check_frame(C_A, S_A, 4'b0000, 4'b0100, t);
    repeat (5) @(negedge clk_50m);
    n_cmp++;
    if (cur_src_a !== 2'd2) begin
      n_err++;
      $display("FAIL cur_src_hold: got %0d, required 2", cur_src_a);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t1;
    int t2;
    bit seen;
    sel_b = 1'b0;
    data_a = {8'hC5, 8'hE6, 8'h00, 8'h81};
    req_a = 4'b0100;
    seen = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk_50m);
      if (ack_a !== 4'b0000) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen || ack_a !== 4'b0100) begin
      n_err++;
      $display("FAIL abort_grant: got ack=%b, required 0100", ack_a);
    end
    req_a = 4'b0000;
    repeat (4 * C_A + C_A / 2) @(negedge clk_50m);
    n_cmp++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL data_bit3: got tx=%b busy=%b, required tx=0 busy=1", tx_a, busy_a);
    end
    #3;
    rst = 1'b1;
    req_a = 4'b1001;
    #1;
    n_cmp++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || ack_a !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset: got tx=%b busy=%b ack=%b, required 1 0 0000",
               tx_a, busy_a, ack_a);
    end
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    sb_q.push_back('{src: 2'd0, byte_v: 8'h81});
    sb_q.push_back('{src: 2'd3, byte_v: 8'hC5});
    check_frame(C_A, S_A, 4'b0000, 4'b0001, t1);
    check_frame(C_A, S_A, 4'b0000, 4'b1000, t2);
    n_cmp++;
    if (t2 - t1 != 4341) begin
      n_err++;
      $display("FAIL post_reset_spacing: got %0d cycles, required 4341", t2 - t1);
    end
  endtask

  task automatic test_small_params();
    int t1;
    int t2;
    sel_b = 1'b1;
    data_b[7:0]  = 8'hA3;
    data_b[15:8] = 8'h3C;
    sb_q.push_back('{src: 2'd0, byte_v: 8'hA3});
    sb_q.push_back('{src: 2'd1, byte_v: 8'h3C});
    req_b = 4'b0011;
    check_frame(C_B, S_B, 4'b0000, 4'b0001, t1);
    check_frame(C_B, S_B, 4'b0000, 4'b0010, t2);
    n_cmp++;
    if (t2 - t1 != 45) begin
      n_err++;
      $display("FAIL small_spacing: got %0d cycles, required 45", t2 - t1);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left: got %0d entries, required 0", sb_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    sel_b = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    data_a = 32'h0;
    data_b = 32'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_late_request();
    test_reset_mid_frame();
    test_small_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
